// File: rtl/ram_bus_arbiter_pkg.sv
// Shared types and constants for the RAM_64Kx8 bus arbiter (state encoding, bus owner, vector addresses).
package ram_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_VEC_LO = 3'd1,
    ST_VEC_HI = 3'd2,
    ST_RUN    = 3'd3,
    ST_STALL  = 3'd4,
    ST_DMA    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OWN_CPU,
    OWN_DMA,
    OWN_VEC
  } owner_e;

  localparam logic [15:0] RAM_VEC_LO = 16'hfffc;
  localparam logic [15:0] RAM_VEC_HI = 16'hfffd;

endpackage

// File: rtl/ram_bus_arbiter_mux.sv
// Combinational RAM bus steering: picks address, write data and active-low write strobe
// from the CPU, the DMA requester or the internal reset-vector writer.
module ram_bus_mux
  import ram_bus_arbiter_pkg::*;
(
  input  owner_e      owner,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_db,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic [15:0] vec_addr,
  input  logic [7:0]  vec_data,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_write_x
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    ram_addr    = cpu_ab;
    ram_data    = cpu_db;
    ram_write_x = cpu_rw;
    unique case (owner)
      OWN_DMA: begin
        ram_addr    = dma_addr;
        ram_data    = dma_wdata;
        ram_write_x = ~(dma_req & dma_we);
      end
      OWN_VEC: begin
        ram_addr    = vec_addr;
        ram_data    = vec_data;
        ram_write_x = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares RAM_64Kx8 between the MC6502 and a loader/DMA requester; holds the CPU in reset during boot
// and steals cycles via RDY. Optional reset-vector write enabled by RAM_BUS_ARB_RESET_VECTOR_INIT_EN.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int unsigned DMA_MAX_BURST = 8,
  parameter logic [15:0] RESET_VECTOR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic [15:0] i_cpu_ab,
  input  logic        i_cpu_rw,
  input  logic [7:0]  i_cpu_db,
  output logic [7:0]  o_cpu_db,
  output logic        o_cpu_rdy,
  output logic        o_cpu_rst_x,
  input  logic        i_dma_req,
  input  logic        i_dma_we,
  input  logic [15:0] i_dma_addr,
  input  logic [7:0]  i_dma_wdata,
  output logic        o_dma_ack,
  output logic [7:0]  o_dma_rdata,
  input  logic        i_boot_done,
  output logic [15:0] o_ram_addr,
  output logic [7:0]  o_ram_data,
  output logic        o_ram_write_x,
  input  logic [7:0]  i_ram_data
);

  localparam logic [7:0] BURST_LAST = 8'(DMA_MAX_BURST - 1);

  state_e      state, state_next;
  logic [7:0]  count, count_next;
  logic        cpu_rdy, cpu_rst_x;
  owner_e      owner;
  logic        dma_ack;
  logic [15:0] vec_addr;
  logic [7:0]  vec_data;
  logic        ram_write_x_raw;

  always_comb begin
    state_next = state;
    count_next = count;
    owner      = OWN_CPU;
    dma_ack    = 1'b0;
    vec_addr   = RAM_VEC_LO;
    vec_data   = RESET_VECTOR[7:0];
    unique case (state)
      ST_BOOT: begin
        owner   = OWN_DMA;
        dma_ack = i_dma_req;
        if (i_boot_done) begin
`ifdef RAM_BUS_ARB_RESET_VECTOR_INIT_EN
          state_next = ST_VEC_LO;
`else
          state_next = ST_RUN;
`endif
        end
      end
      ST_VEC_LO: begin
        owner      = OWN_VEC;
        state_next = ST_VEC_HI;
      end
      ST_VEC_HI: begin
        owner      = OWN_VEC;
        vec_addr   = RAM_VEC_HI;
        vec_data   = RESET_VECTOR[15:8];
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (i_dma_req) state_next = ST_STALL;
      end
      ST_STALL: begin
        // The 6502 ignores RDY on writes, so the grant waits for a read cycle to freeze it.
        if (!i_dma_req)    state_next = ST_RUN;
        else if (i_cpu_rw) state_next = ST_DMA;
      end
      ST_DMA: begin
        owner   = OWN_DMA;
        dma_ack = i_dma_req;
        if (!i_dma_req || count >= BURST_LAST) begin
          state_next = ST_RUN;
          count_next = '0;
        end else if (count != 8'hff) begin
          count_next = count + 8'd1;
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_x) begin
      state     <= ST_BOOT;
      count     <= '0;
      cpu_rst_x <= 1'b0;
      cpu_rdy   <= 1'b1;
    end else begin
      state     <= state_next;
      count     <= count_next;
      cpu_rst_x <= cpu_rst_x | (state_next == ST_RUN);
      cpu_rdy   <= !(state_next inside {ST_STALL, ST_DMA});
    end
  end

  ram_bus_mux u_mux (
    .owner       (owner),
    .cpu_ab      (i_cpu_ab),
    .cpu_rw      (i_cpu_rw),
    .cpu_db      (i_cpu_db),
    .dma_req     (i_dma_req),
    .dma_we      (i_dma_we),
    .dma_addr    (i_dma_addr),
    .dma_wdata   (i_dma_wdata),
    .vec_addr    (vec_addr),
    .vec_data    (vec_data),
    .ram_addr    (o_ram_addr),
    .ram_data    (o_ram_data),
    .ram_write_x (ram_write_x_raw)
  );

  // A reset cycle aborts whatever beat is on the bus: no ack and no write lands.
  assign o_dma_ack     = dma_ack & rst_x;
  assign o_ram_write_x = ram_write_x_raw | ~rst_x;
  assign o_cpu_rdy     = cpu_rdy;
  assign o_cpu_rst_x   = cpu_rst_x;
  assign o_cpu_db      = i_ram_data;
  assign o_dma_rdata   = i_ram_data;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: directed boot/steal/burst/reset scenarios plus random
// traffic, checked every cycle against a behavioural model and a reference RAM image.
module tb_ram_bus_arbiter;

  localparam int          MAX_BURST = 4;
  localparam logic [15:0] TB_VECTOR = 16'hc35a;

  logic        clk = 1'b0;
  logic        rst_x = 1'b0;
  logic [15:0] i_cpu_ab = '0;
  logic        i_cpu_rw = 1'b1;
  logic [7:0]  i_cpu_db = '0;
  logic [7:0]  o_cpu_db;
  logic        o_cpu_rdy, o_cpu_rst_x;
  logic        i_dma_req = 1'b0, i_dma_we = 1'b0;
  logic [15:0] i_dma_addr = '0;
  logic [7:0]  i_dma_wdata = '0;
  logic        o_dma_ack;
  logic [7:0]  o_dma_rdata;
  logic        i_boot_done = 1'b0;
  logic [15:0] o_ram_addr;
  logic [7:0]  o_ram_data;
  logic        o_ram_write_x;
  logic [7:0]  i_ram_data;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.DMA_MAX_BURST(MAX_BURST), .RESET_VECTOR(TB_VECTOR)) dut (
    .clk(clk), .rst_x(rst_x),
    .i_cpu_ab(i_cpu_ab), .i_cpu_rw(i_cpu_rw), .i_cpu_db(i_cpu_db), .o_cpu_db(o_cpu_db),
    .o_cpu_rdy(o_cpu_rdy), .o_cpu_rst_x(o_cpu_rst_x),
    .i_dma_req(i_dma_req), .i_dma_we(i_dma_we), .i_dma_addr(i_dma_addr),
    .i_dma_wdata(i_dma_wdata), .o_dma_ack(o_dma_ack), .o_dma_rdata(o_dma_rdata),
    .i_boot_done(i_boot_done),
    .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data), .o_ram_write_x(o_ram_write_x),
    .i_ram_data(i_ram_data)
  );

  // The RAM itself: asynchronous read, write on the clock edge while the strobe is low.
  logic [7:0] mem [0:65535] = '{default: 8'h00};
  assign i_ram_data = mem[o_ram_addr];
  always @(posedge clk) if (!o_ram_write_x) mem[o_ram_addr] <= o_ram_data;

  // Behavioural model: what the arbiter should be doing, in terms of who is allowed to move.
  logic [7:0] ref_mem [0:65535] = '{default: 8'h00};
  bit m_booted, m_released, m_halted, m_granted;
  int m_vec_left, m_beats;

  int n_checks = 0, n_fail = 0;
  logic       last_ack, s_rst_out, s_rdy;
  logic [7:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_booted = 0; m_released = 0; m_halted = 0; m_granted = 0; m_vec_left = 0; m_beats = 0;
  endtask

  task automatic model_end_burst();
    m_granted = 0; m_halted = 0; m_beats = 0;
  endtask

  // One clock cycle: compare at the falling edge, then advance the model over the rising edge.
  task automatic step();
    int          own;
    logic        exp_ack, exp_wx;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    @(negedge clk);
    own = !m_booted ? 1 : (m_vec_left > 0) ? 2 : m_granted ? 1 : 0;
    exp_addr = i_cpu_ab; exp_data = i_cpu_db; exp_wx = i_cpu_rw;
    if (own == 1) begin
      exp_addr = i_dma_addr; exp_data = i_dma_wdata; exp_wx = !(i_dma_req && i_dma_we);
    end else if (own == 2) begin
      exp_addr = (m_vec_left == 2) ? 16'hfffc : 16'hfffd;
      exp_data = (m_vec_left == 2) ? TB_VECTOR[7:0] : TB_VECTOR[15:8];
      exp_wx   = 1'b0;
    end
    if (!rst_x) exp_wx = 1'b1;
    exp_ack = rst_x && i_dma_req && (own == 1);
    check("dma_ack", o_dma_ack, exp_ack);
    check("cpu_rdy", o_cpu_rdy, !m_halted);
    check("cpu_rst_x", o_cpu_rst_x, m_released);
    check("ram_write_x", o_ram_write_x, exp_wx);
    check("ram_addr", o_ram_addr, exp_addr);
    if (!exp_wx) check("ram_data", o_ram_data, exp_data);
    if (exp_ack && !i_dma_we) check("dma_rdata", o_dma_rdata, ref_mem[exp_addr]);
    check("cpu_db", o_cpu_db, ref_mem[exp_addr]);
    last_ack = o_dma_ack; last_rdata = o_dma_rdata; s_rst_out = o_cpu_rst_x; s_rdy = o_cpu_rdy;
    @(posedge clk);
    if (!exp_wx) ref_mem[exp_addr] = exp_data;
    if (!rst_x) model_reset();
    else if (!m_booted) begin
      if (i_boot_done) begin
        m_booted = 1;
`ifdef RAM_BUS_ARB_RESET_VECTOR_INIT_EN
        m_vec_left = 2;
`else
        m_released = 1;
`endif
      end
    end else if (m_vec_left > 0) begin
      m_vec_left--;
      if (m_vec_left == 0) m_released = 1;
    end else if (m_granted) begin
      if (!i_dma_req) model_end_burst();
      else begin
        m_beats++;
        if (m_beats == MAX_BURST) model_end_burst();
      end
    end else if (m_halted) begin
      if (!i_dma_req) m_halted = 0;
      else if (i_cpu_rw) m_granted = 1;
    end else if (i_dma_req) m_halted = 1;
    #1;
  endtask

  task automatic dma_beat(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                          output int cycles, output logic [7:0] rd);
    i_dma_req = 1'b1; i_dma_we = we; i_dma_addr = addr; i_dma_wdata = wd;
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!last_ack && cycles < 50);
    check("dma_beat_done", last_ack, 1'b1);
    rd = last_rdata;
    i_dma_req = 1'b0;
  endtask

  task automatic boot_release(input string tag);
    int lat;
    i_boot_done = 1'b1;
    step();
    i_boot_done = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!s_rst_out && lat < 10);
`ifdef RAM_BUS_ARB_RESET_VECTOR_INIT_EN
    check(tag, lat, 3);
`else
    check(tag, lat, 1);
`endif
  endtask

  initial begin
    int         cyc, runlen, max_run, groups, beats, guard;
    logic [7:0] rd;
    bit         pend;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    repeat (2) step();

    // Boot load, each beat acked in its first cycle.
    rst_x = 1'b1;
    dma_beat(1'b1, 16'h0000, 8'ha9, cyc, rd); check("boot_beat0_cycles", cyc, 1);
    dma_beat(1'b1, 16'h0001, 8'h42, cyc, rd); check("boot_beat1_cycles", cyc, 1);
    dma_beat(1'b1, 16'h0002, 8'hff, cyc, rd); check("boot_beat2_cycles", cyc, 1);
    boot_release("release_latency");
    check("ram_0000", mem[16'h0000], 8'ha9);
    check("ram_0001", mem[16'h0001], 8'h42);
    check("ram_0002", mem[16'h0002], 8'hff);
`ifdef RAM_BUS_ARB_RESET_VECTOR_INIT_EN
    check("ram_fffc", mem[16'hfffc], TB_VECTOR[7:0]);
    check("ram_fffd", mem[16'hfffd], TB_VECTOR[15:8]);
`else
    check("ram_fffc", mem[16'hfffc], 8'h00);
    check("ram_fffd", mem[16'hfffd], 8'h00);
`endif

    // Steal on a CPU read: RUN, STALL, then the DMA beat.
    i_cpu_rw = 1'b1; i_cpu_ab = 16'h0200;
    repeat (2) step();
    dma_beat(1'b0, 16'h0001, 8'h00, cyc, rd);
    check("steal_read_cycles", cyc, 3);
    check("steal_read_data", rd, 8'h42);
    step();
    step();
    check("steal_return_rdy", s_rdy, 1'b1);

    // Steal during CPU writes: stall holds, writes land, grant only once the CPU reads.
    i_dma_req = 1'b1; i_dma_we = 1'b0; i_dma_addr = 16'h0002;
    step();
    for (int i = 0; i < 3; i++) begin
      i_cpu_rw = 1'b0; i_cpu_ab = 16'h0300 + 16'(i); i_cpu_db = 8'h5c + 8'(i);
      step();
      check("stall_write_no_ack", last_ack, 1'b0);
    end
    i_cpu_rw = 1'b1; i_cpu_ab = 16'h0210;
    dma_beat(1'b0, 16'h0002, 8'h00, cyc, rd);
    check("stall_grant_cycles", cyc, 2);
    check("stall_read_data", rd, 8'hff);
    for (int i = 0; i < 3; i++) check("stall_cpu_write", mem[16'h0300 + 16'(i)], 8'h5c + 8'(i));
    step();

    // Burst limit: ten beats with the request held throughout.
    runlen = 0; max_run = 0; groups = 0; beats = 0; guard = 0;
    i_dma_req = 1'b1; i_dma_we = 1'b1; i_dma_addr = 16'h0400; i_dma_wdata = 8'h10;
    while (beats < 10 && guard < 100) begin
      step();
      guard++;
      if (last_ack) begin
        beats++; runlen++;
        if (runlen == 1) groups++;
        if (runlen > max_run) max_run = runlen;
        i_dma_addr = 16'h0400 + 16'(beats); i_dma_wdata = 8'h10 + 8'(beats);
      end else runlen = 0;
    end
    i_dma_req = 1'b0;
    check("burst_beats", beats, 10);
    check("burst_max_run", max_run, MAX_BURST);
    check("burst_groups", groups, 3);
    step();
    step();
    check("burst_last_write", mem[16'h0409], 8'h19);

    // Reset during a DMA beat aborts it.
    i_dma_req = 1'b1; i_dma_we = 1'b1; i_dma_addr = 16'h1234; i_dma_wdata = 8'h77;
    guard = 0;
    while (!m_granted && guard < 10) begin step(); guard++; end
    check("reset_reached_dma", m_granted, 1'b1);
    rst_x = 1'b0;
    step();
    check("reset_abort_ack", last_ack, 1'b0);
    rst_x = 1'b1; i_dma_req = 1'b0;
    step();
    check("reset_cpu_rst", s_rst_out, 1'b0);
    check("reset_cpu_rdy", s_rdy, 1'b1);
    check("reset_no_write", mem[16'h1234], 8'h00);

    // Re-boot, then random CPU and DMA traffic against the model.
    boot_release("reboot_latency");
    pend = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1;
        i_dma_req = 1'b1; i_dma_we = 1'($urandom_range(0, 1));
        i_dma_addr = 16'($urandom_range(0, 63)); i_dma_wdata = 8'($urandom);
      end
      if (o_cpu_rdy || !i_cpu_rw) begin
        i_cpu_rw = ($urandom_range(0, 3) != 0);
        i_cpu_ab = 16'($urandom_range(0, 63)); i_cpu_db = 8'($urandom);
      end
      step();
      if (pend && last_ack) begin
        pend = 0;
        i_dma_req = 1'b0;
      end
    end
    i_dma_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
